// File: rtl/stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stim_sequencer
// Purpose  : Table-driven stimulus sequencer. Plays a programmed list of timed
//            steps: set one analog stimulus channel, send a command byte
//            through a UART_tx style trmt/tx_done handshake, wait, or end.
//            The result is a reloadable, cycle-exact replacement for
//            hand-written repeat/assign stimulus sequences.
//
// Ports    : clk       in   system clock
//            rst       in   asynchronous active-high reset
//            wr_en     in   table write strobe (ignored while busy)
//            wr_addr   in   table write address            [AW-1:0]
//            wr_data   in   entry {op[1:0], ch, value, wait} [EW-1:0]
//            start     in   begin playback at entry 0 (ignored while busy)
//            abort     in   stop playback immediately (wins over start)
//            tx_done   in   UART_tx completion pulse
//            trmt      out  one-cycle UART send strobe
//            tx_data   out  command byte
//            ch_val    out  flattened channel values, channel k at
//                           [k*VAL_W +: VAL_W]
//            step_idx  out  address of the current or last executed step
//            busy      out  playback active
//            done      out  sticky playback-finished flag
//
// Op codes : 0 SET, 1 CMD, 2 WAIT, 3 END
//
// Options  : SEQ_LOOP_EN - when defined, an END entry with value != 0 is a
//            single-level loop-back: wait[AW-1:0] is the target address and
//            value is the number of extra passes over the loop body.
//
// Revision : 1.0 - initial release
// ============================================================================
module stim_sequencer #(
    parameter int N_CH  = 4,
    parameter int VAL_W = 16,
    parameter int DEPTH = 32,
    parameter int CNT_W = 24,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int EW   = 2 + CH_W + VAL_W + CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [EW-1:0]         wr_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  tx_done,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    output logic [N_CH*VAL_W-1:0] ch_val,
    output logic [AW-1:0]         step_idx,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0]    c_OP_SET  = 2'd0;
    localparam logic [1:0]    c_OP_CMD  = 2'd1;
    localparam logic [1:0]    c_OP_WAIT = 2'd2;
    localparam logic [1:0]    c_OP_END  = 2'd3;
    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_TX_WAIT = 3'd3,
        S_DELAY   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;

    logic [EW-1:0]         r_mem [DEPTH];
    logic [EW-1:0]         r_entry;
    logic [AW-1:0]         r_step_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_trmt;
    logic [7:0]            r_tx_data;
    logic [N_CH*VAL_W-1:0] r_ch_val;
    logic [CNT_W-1:0]      r_cnt;

    // Fields of the entry currently being executed
    logic [1:0]            w_op;
    logic [CH_W-1:0]       w_ch;
    logic [VAL_W-1:0]      w_val;
    logic [CNT_W-1:0]      w_wait;

    assign {w_op, w_ch, w_val, w_wait} = r_entry;

    // Action strobes produced by the next-state logic
    logic                  w_start;     // (re)start playback at entry 0
    logic                  w_set;       // write one channel value
    logic                  w_cmd;       // launch a UART command byte
    logic                  w_post;      // step body complete, apply its wait
    logic                  w_ld_cnt;    // enter DELAY with wait-1 loaded
    logic                  w_dec_cnt;   // count one DELAY cycle
    logic                  w_adv;       // move past the current step
    logic                  w_next;      // advance to step_idx+1
    logic                  w_finish;    // playback complete
    logic                  w_jump;      // loop-back to an arbitrary entry

`ifdef SEQ_LOOP_EN
    logic                  r_loop_act;  // loop-back END has been reached once
    logic [VAL_W-1:0]      r_loop_rem;  // extra passes still owed
    logic                  w_loop_first;
    logic                  w_loop_dec;
`endif

    // ------------------------------------------------------------------
    // Step table. Writes are locked out during playback so the running
    // program cannot be modified underneath the sequencer. The read is
    // registered: the entry addressed in FETCH is valid in EXEC.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !r_busy) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (r_state == S_FETCH) begin
            r_entry <= r_mem[r_step_idx];
        end
    end

    // ------------------------------------------------------------------
    // Next-state and action decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_set       = 1'b0;
        w_cmd       = 1'b0;
        w_post      = 1'b0;
        w_ld_cnt    = 1'b0;
        w_dec_cnt   = 1'b0;
        w_adv       = 1'b0;
        w_next      = 1'b0;
        w_finish    = 1'b0;
        w_jump      = 1'b0;
`ifdef SEQ_LOOP_EN
        w_loop_first = 1'b0;
        w_loop_dec   = 1'b0;
`endif

        if (abort) begin
            // Abort beats everything, including a simultaneous start.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end

                S_FETCH: begin
                    w_state_nxt = S_EXEC;
                end

                S_EXEC: begin
                    case (w_op)
                        c_OP_SET: begin
                            w_set  = 1'b1;
                            w_post = 1'b1;
                        end
                        c_OP_CMD: begin
                            w_cmd       = 1'b1;
                            w_state_nxt = S_TX_WAIT;
                        end
                        c_OP_WAIT: begin
                            w_post = 1'b1;
                        end
                        c_OP_END: begin
`ifdef SEQ_LOOP_EN
                            if ((w_val != '0) && (!r_loop_act || (r_loop_rem != '0))) begin
                                w_jump       = 1'b1;
                                w_loop_first = !r_loop_act;
                                w_loop_dec   = r_loop_act;
                                w_state_nxt  = S_FETCH;
                            end else begin
                                w_finish    = 1'b1;
                                w_state_nxt = S_DONE;
                            end
`else
                            w_finish    = 1'b1;
                            w_state_nxt = S_DONE;
`endif
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end

                S_TX_WAIT: begin
                    // r_trmt is still high in the first TX_WAIT cycle; a
                    // tx_done coincident with the strobe belongs to an
                    // earlier transfer and is ignored.
                    if (tx_done && !r_trmt) begin
                        w_post = 1'b1;
                    end
                end

                S_DELAY: begin
                    if (r_cnt == '0) begin
                        w_adv = 1'b1;
                    end else begin
                        w_dec_cnt = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Post-step: a zero wait advances straight away, otherwise DELAY
        // runs for exactly `wait` cycles (counter loaded with wait-1).
        if (w_post) begin
            if (w_wait == '0) begin
                w_adv = 1'b1;
            end else begin
                w_ld_cnt    = 1'b1;
                w_state_nxt = S_DELAY;
            end
        end

        // The table does not wrap: running off the last entry ends playback.
        if (w_adv) begin
            if (r_step_idx == c_LAST_IDX) begin
                w_finish    = 1'b1;
                w_state_nxt = S_DONE;
            end else begin
                w_next      = 1'b1;
                w_state_nxt = S_FETCH;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_trmt     <= 1'b0;
            r_tx_data  <= '0;
            r_ch_val   <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Single-cycle strobe; also drops on abort since w_cmd is 0 then.
            r_trmt <= w_cmd;
            if (w_cmd) begin
                r_tx_data <= w_val[7:0];
            end

            if (abort) begin
                r_busy <= 1'b0;
            end else if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end

            // done is sticky across abort; only a new start clears it.
            if (w_start) begin
                r_done <= 1'b0;
            end else if (w_finish) begin
                r_done <= 1'b1;
            end

            if (w_ld_cnt) begin
                r_cnt <= w_wait - 1'b1;
            end else if (w_dec_cnt) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_start) begin
                r_step_idx <= '0;
            end else if (w_jump) begin
                r_step_idx <= w_wait[AW-1:0];
            end else if (w_next) begin
                r_step_idx <= r_step_idx + 1'b1;
            end

            // A channel number with no matching channel simply writes
            // nothing; the step still completes normally.
            for (int k = 0; k < N_CH; k++) begin
                if (w_set && (w_ch == CH_W'(k))) begin
                    r_ch_val[k*VAL_W +: VAL_W] <= w_val;
                end
            end
        end
    end

`ifdef SEQ_LOOP_EN
    // ------------------------------------------------------------------
    // Single-level loop bookkeeping. The first arrival at a loop-back END
    // arms the loop with value-1 remaining passes; later arrivals consume
    // them until none remain and the END finally terminates playback.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loop_act <= 1'b0;
            r_loop_rem <= '0;
        end else if (w_start) begin
            r_loop_act <= 1'b0;
            r_loop_rem <= '0;
        end else if (w_loop_first) begin
            r_loop_act <= 1'b1;
            r_loop_rem <= w_val - 1'b1;
        end else if (w_loop_dec) begin
            r_loop_rem <= r_loop_rem - 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign trmt     = r_trmt;
    assign tx_data  = r_tx_data;
    assign ch_val   = r_ch_val;
    assign step_idx = r_step_idx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stim_sequencer
// Purpose  : Self-checking bench for stim_sequencer. Programs step tables,
//            predicts every channel update, UART strobe and completion time
//            from the step timing rules, and compares against the DUT.
//            N_CH=3 leaves channel code 3 unused for the bad-channel case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stim_sequencer;

    localparam int N_CH  = 3;
    localparam int VAL_W = 16;
    localparam int DEPTH = 16;
    localparam int CNT_W = 24;
    localparam int CH_W  = 2;
    localparam int AW    = 4;
    localparam int EW    = 2 + CH_W + VAL_W + CNT_W;
    localparam int CHV_W = N_CH * VAL_W;

    localparam logic [1:0] OP_SET  = 2'd0;
    localparam logic [1:0] OP_CMD  = 2'd1;
    localparam logic [1:0] OP_WAIT = 2'd2;
    localparam logic [1:0] OP_END  = 2'd3;

    localparam int TX_LAT = 3;     // negedges between trmt and tx_done
    localparam int STALL  = 40;    // hold-off used by the stall scenario
    localparam int LIMIT  = 3000;  // cycle budget when waiting for done

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [EW-1:0]    wr_data = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             tx_done = 1'b0;
    logic             trmt;
    logic [7:0]       tx_data;
    logic [CHV_W-1:0] ch_val;
    logic [AW-1:0]    step_idx;
    logic             busy;
    logic             done;

    stim_sequencer #(
        .N_CH (N_CH),
        .VAL_W(VAL_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .abort   (abort),
        .tx_done (tx_done),
        .trmt    (trmt),
        .tx_data (tx_data),
        .ch_val  (ch_val),
        .step_idx(step_idx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Shadow table, model state and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]       op;
        logic [1:0]       ch;
        logic [VAL_W-1:0] val;
        logic [CNT_W-1:0] w;
    } ent_t;

    typedef struct {
        int               cyc;
        bit               is_tx;
        logic [7:0]       b;
        logic [CHV_W-1:0] chv;
    } ev_t;

    typedef struct {
        logic [1:0]       ch;
        logic [VAL_W-1:0] val;
        logic [CNT_W-1:0] w;
        logic [CHV_W-1:0] exp;
    } vec_t;

    ent_t             shadow [DEPTH];
    ev_t              sb[$];
    logic [CHV_W-1:0] m_ch = '0;
    int               tx_mode = 0;
    bit               mon_en = 1'b0;
    logic [CHV_W-1:0] prev_ch = '0;

    // Monitor: every strobe or channel change must match the next
    // predicted event in both cycle and value.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && trmt === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_trmt: got tx_data 0x%0h, expected no strobe (cycle %0d)", tx_data, cyc);
            end else begin
                e = sb.pop_front();
                check("ev_is_tx", 64'(e.is_tx), 64'd1);
                check("tx_cycle", 64'(cyc), 64'(e.cyc));
                check("tx_data", 64'(tx_data), 64'(e.b));
            end
        end
        if (mon_en && ch_val !== prev_ch) begin
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_ch: got 0x%0h, expected 0x%0h (cycle %0d)", ch_val, prev_ch, cyc);
            end else begin
                e = sb.pop_front();
                check("ev_is_ch", 64'(e.is_tx), 64'd0);
                check("ch_cycle", 64'(cyc), 64'(e.cyc));
                check("ch_val", 64'(ch_val), 64'(e.chv));
            end
        end
        prev_ch = ch_val;
    end

    // UART_tx stand-in. Mode 1 first pulses tx_done in the strobe cycle
    // (must be ignored), then withholds it for STALL cycles.
    always begin
        @(negedge clk);
        if (trmt === 1'b1) begin
            if (tx_mode == 0) begin
                repeat (TX_LAT) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end else begin
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                repeat (STALL) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    // Timing model: FETCH at t, step effect visible at t+2, next FETCH
    // after the step's wait; CMD steps also wait for the tx_done edge.
    task automatic run_model(input int t0, output int dcyc, output int lidx);
        int   t = t0;
        int   i = 0;
        int   ex;
        int   nxt;
        int   txl;
        bit   lact = 1'b0;
        int   lrem = 0;
        ent_t e;
        ev_t  ev;
        dcyc = -1;
        lidx = -1;
        txl  = (tx_mode == 0) ? TX_LAT : STALL + 1;
        for (int n = 0; n < 200; n++) begin
            e   = shadow[i];
            ex  = t + 2;
            nxt = ex + int'(e.w);
            case (e.op)
                OP_SET: begin
                    if (int'(e.ch) < N_CH && m_ch[int'(e.ch)*VAL_W +: VAL_W] != e.val) begin
                        m_ch[int'(e.ch)*VAL_W +: VAL_W] = e.val;
                        ev = '{ex, 1'b0, 8'h00, m_ch};
                        sb.push_back(ev);
                    end
                end
                OP_CMD: begin
                    ev = '{ex, 1'b1, e.val[7:0], m_ch};
                    sb.push_back(ev);
                    nxt = ex + 1 + txl + int'(e.w);
                end
                OP_WAIT: ;
                default: begin
`ifdef SEQ_LOOP_EN
                    if (e.val != 0 && (!lact || lrem > 0)) begin
                        if (!lact) begin
                            lact = 1'b1;
                            lrem = int'(e.val) - 1;
                        end else begin
                            lrem--;
                        end
                        i = int'(e.w[AW-1:0]);
                        t = ex;
                        continue;
                    end
`endif
                    dcyc = ex;
                    lidx = i;
                    return;
                end
            endcase
            if (i == DEPTH - 1) begin
                dcyc = nxt;
                lidx = i;
                return;
            end
            i++;
            t = nxt;
        end
    endtask

    task automatic write_entry(input int a, input logic [1:0] op, input logic [1:0] ch,
                               input logic [VAL_W-1:0] v, input logic [CNT_W-1:0] w);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = {op, ch, v, w};
        @(negedge clk);
        wr_en   = 1'b0;
        shadow[a].op  = op;
        shadow[a].ch  = ch;
        shadow[a].val = v;
        shadow[a].w   = w;
    endtask

    task automatic start_prog(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic finish_prog(input string tag, input int dcyc, input int lidx);
        int seen = -1;
        for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = cyc;
                break;
            end
        end
        check({tag, "_done_cycle"}, 64'(seen), 64'(dcyc));
        check({tag, "_step_idx"}, 64'(step_idx), 64'(lidx));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run(input string tag);
        int t0, d, l;
        start_prog(t0);
        run_model(t0, d, l);
        finish_prog(tag, d, l);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t vecs [5];
        int   t0, d, l;

        // Single-step SET vectors; expected ch_val accumulates {ch2,ch1,ch0}.
        vecs[0] = '{2'd0, 16'h1111, 24'd0, 48'h0000_0300_1111};
        vecs[1] = '{2'd2, 16'hABCD, 24'd2, 48'hABCD_0300_1111};
        vecs[2] = '{2'd1, 16'h0A0A, 24'd1, 48'hABCD_0A0A_1111};
        vecs[3] = '{2'd3, 16'h5555, 24'd0, 48'hABCD_0A0A_1111};
        vecs[4] = '{2'd0, 16'hFFFF, 24'd3, 48'hABCD_0A0A_FFFF};

        // Reset and hold
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_ch_val", 64'(ch_val), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_trmt", 64'(trmt), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_step_idx", 64'(step_idx), 64'd0);

        // Basic SET timing: ch0 at start+2, ch1 12 cycles later
        write_entry(0, OP_SET, 2'd0, 16'h0300, 24'd10);
        write_entry(1, OP_SET, 2'd1, 16'h0300, 24'd0);
        write_entry(2, OP_END, 2'd0, 16'h0000, 24'd0);
        run("basic");
        check("basic_done", 64'(done), 64'd1);

        // Table-driven single SET steps, including an unmapped channel
        for (int i = 0; i < 5; i++) begin
            write_entry(0, OP_SET, vecs[i].ch, vecs[i].val, vecs[i].w);
            write_entry(1, OP_END, 2'd0, 16'h0000, 24'd0);
            run($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ch_val", i), 64'(ch_val), 64'(vecs[i].exp));
        end

        // UART handshake
        tx_mode = 0;
        write_entry(0, OP_CMD, 2'd0, 16'h0047, 24'd5);
        write_entry(1, OP_CMD, 2'd0, 16'h0053, 24'd0);
        write_entry(2, OP_END, 2'd0, 16'h0000, 24'd0);
        run("uart");
        check("uart_tx_data", 64'(tx_data), 64'h53);

        // Stall: coincident tx_done ignored, then tx_done withheld
        tx_mode = 1;
        write_entry(0, OP_CMD, 2'd0, 16'h0011, 24'd0);
        write_entry(1, OP_END, 2'd0, 16'h0000, 24'd0);
        start_prog(t0);
        run_model(t0, d, l);
        repeat (30) @(negedge clk);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_done", 64'(done), 64'd0);
        check("stall_step_idx", 64'(step_idx), 64'd0);
        finish_prog("stall", d, l);
        tx_mode = 0;

        // Abort during a long DELAY
        write_entry(0, OP_SET, 2'd2, 16'h7777, 24'd1000);
        write_entry(1, OP_SET, 2'd0, 16'h2222, 24'd0);
        write_entry(2, OP_END, 2'd0, 16'h0000, 24'd0);
        start_prog(t0);
        m_ch[2*VAL_W +: VAL_W] = 16'h7777;
        sb.push_back('{t0 + 2, 1'b0, 8'h00, m_ch});
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ch_val", 64'(ch_val), 64'(m_ch));
        check("abort_step_idx", 64'(step_idx), 64'd0);
        check("abort_sb_left", 64'(sb.size()), 64'd0);

        // Simultaneous start and abort: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        check("start_abort_busy", 64'(busy), 64'd0);

        // Replay from entry 0; a write while busy must not land
        write_entry(0, OP_SET, 2'd2, 16'h7778, 24'd2);
        start_prog(t0);
        run_model(t0, d, l);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(1);
        wr_data = {OP_SET, 2'd0, 16'h9999, 24'd0};
        @(negedge clk);
        wr_en   = 1'b0;
        finish_prog("replay", d, l);

        // Full table with no END: stops after the last entry
        for (int i = 0; i < DEPTH; i++) begin
            write_entry(i, OP_SET, 2'(i % 3), 16'(16'h1000 + i), 24'((i % 4 == 3) ? 2 : 0));
        end
        run("full");

        // Loop-back END (value=2, target=1); runs once without the option
        write_entry(0, OP_SET, 2'd1, 16'h0101, 24'd0);
        write_entry(1, OP_SET, 2'd2, 16'h0202, 24'd3);
        write_entry(2, OP_END, 2'd0, 16'h0002, 24'd1);
        run("loop");

        // Asynchronous reset mid-playback
        mon_en = 1'b0;
        write_entry(0, OP_SET, 2'd1, 16'h4444, 24'd50);
        write_entry(1, OP_END, 2'd0, 16'h0000, 24'd0);
        start_prog(t0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ch_val", 64'(ch_val), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_tx_data", 64'(tx_data), 64'd0);
        check("arst_step_idx", 64'(step_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
